// File: rtl/motor_speed_recip.sv
// Multi-channel motor speed estimator: per-channel pulse period counters feed a
// shared round-robin restoring divider that yields clamped reciprocal speed codes.
module motor_speed_recip #(
  parameter int CHANNELS  = 4,
  parameter int PERIOD_W  = 16,
  parameter int OUT_W     = 8,
  parameter int NUMERATOR = 8296
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick_en,
  input  logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS*OUT_W-1:0] speed_o,
  output logic [CHANNELS-1:0]       upd_o,
  output logic [CHANNELS-1:0]       stall_o,
  output logic                      busy_o
);

  localparam int NUM_W = $clog2(NUMERATOR + 1);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BIT_W = $clog2(NUM_W + 1);
  localparam int CMP_W = (NUM_W > OUT_W) ? NUM_W : OUT_W;
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [OUT_W-1:0]    OUT_MAX = '1;
  localparam logic [NUM_W-1:0]    NUM_VAL = NUM_W'(NUMERATOR);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t state, state_n;

  logic [CHANNELS-1:0] pulse_q, armed, pend, pend_stall;
  logic [CHANNELS-1:0] edge_det, stall_evt;
  logic [PERIOD_W-1:0] cnt [CHANNELS];
  logic [PERIOD_W-1:0] pend_period [CHANNELS];

  logic [CH_W-1:0]     ptr, grant_ch, div_ch, hi_ch, lo_ch;
  logic                grant_vld, hi_found, grant_stall, div_stall;
  logic [PERIOD_W-1:0] grant_period, div_period, rem, rem_next;
  logic [PERIOD_W:0]   rem_shift;
  logic                q_bit;
  logic [NUM_W-1:0]    quo, num_sr;
  logic [BIT_W-1:0]    bit_cnt;
  logic [OUT_W-1:0]    result;

  assign edge_det = pulse & ~pulse_q;
  assign busy_o   = (state != IDLE);

  // A stall is reported once: the event clears armed, so it cannot repeat.
  always_comb begin
    stall_evt = '0;
    for (int c = 0; c < CHANNELS; c++)
      stall_evt[c] = armed[c] && !edge_det[c] && (cnt[c] == CNT_MAX);
  end

  // First pending channel at or after ptr, else wrap to the lowest pending one.
  always_comb begin
    hi_found     = 1'b0;
    hi_ch        = '0;
    lo_ch        = '0;
    grant_period = '0;
    grant_stall  = 1'b0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (pend[j] && (CH_W'(j) >= ptr)) begin
        hi_found = 1'b1;
        hi_ch    = CH_W'(j);
      end
      if (pend[j])
        lo_ch = CH_W'(j);
    end
    grant_vld = |pend;
    grant_ch  = hi_found ? hi_ch : lo_ch;
    for (int j = 0; j < CHANNELS; j++) begin
      if (grant_ch == CH_W'(j)) begin
        grant_period = pend_period[j];
        grant_stall  = pend_stall[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q    <= '0;
      armed      <= '0;
      pend       <= '0;
      pend_stall <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c]         <= '0;
        pend_period[c] <= '0;
      end
    end else begin
      pulse_q <= pulse;
      for (int c = 0; c < CHANNELS; c++) begin
        if (edge_det[c])
          cnt[c] <= PERIOD_W'(tick_en);
        else if (tick_en && (cnt[c] != CNT_MAX))
          cnt[c] <= cnt[c] + 1'b1;

        // A request arriving in the grant cycle must survive the grant's clear.
        if ((state == IDLE) && grant_vld && (grant_ch == CH_W'(c)))
          pend[c] <= 1'b0;

        if (edge_det[c]) begin
          if (armed[c]) begin
            pend[c]        <= 1'b1;
            pend_period[c] <= cnt[c];
            pend_stall[c]  <= 1'b0;
          end else begin
            armed[c] <= 1'b1;
          end
        end else if (stall_evt[c]) begin
          armed[c]      <= 1'b0;
          pend[c]       <= 1'b1;
          pend_stall[c] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (grant_vld) state_n = LOAD;
      LOAD: state_n = DIV;
      DIV:  if (bit_cnt == BIT_W'(NUM_W - 1)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rem_shift = {rem, num_sr[NUM_W-1]};
    q_bit     = (rem_shift >= {1'b0, div_period});
    rem_next  = q_bit ? PERIOD_W'(rem_shift - {1'b0, div_period}) : PERIOD_W'(rem_shift);
  end

  always_comb begin
    result = OUT_W'(quo);
    if (div_stall)
      result = '0;
    else if (div_period == '0)
      result = OUT_MAX;
    else if (CMP_W'(quo) > CMP_W'(OUT_MAX))
      result = OUT_MAX;
    else if (quo == '0)
      result = OUT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      div_ch     <= '0;
      div_period <= '0;
      div_stall  <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      num_sr     <= '0;
      bit_cnt    <= '0;
      speed_o    <= '0;
      upd_o      <= '0;
      stall_o    <= '0;
    end else begin
      upd_o <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            div_ch     <= grant_ch;
            div_period <= grant_period;
            div_stall  <= grant_stall;
            ptr        <= (grant_ch == CH_W'(CHANNELS - 1)) ? '0 : grant_ch + 1'b1;
          end
        end
        LOAD: begin
          rem     <= '0;
          quo     <= '0;
          num_sr  <= NUM_VAL;
          bit_cnt <= '0;
        end
        DIV: begin
          rem     <= rem_next;
          quo     <= {quo[NUM_W-2:0], q_bit};
          num_sr  <= num_sr << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        DONE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (div_ch == CH_W'(c)) begin
              speed_o[c*OUT_W +: OUT_W] <= result;
              upd_o[c]                  <= 1'b1;
              stall_o[c]                <= div_stall;
            end
          end
        end
        default: ;
      endcase
      for (int c = 0; c < CHANNELS; c++)
        if (edge_det[c] && !armed[c])
          stall_o[c] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_motor_speed_recip.sv
// Self-checking bench for motor_speed_recip: spec vectors, stall, arbitration,
// overwrite, mid-division reset and randomized edges against a reciprocal model.
module tb_motor_speed_recip;

  localparam int CHANNELS  = 4;
  localparam int PERIOD_W  = 16;
  localparam int OUT_W     = 8;
  localparam int NUMERATOR = 8296;
  localparam int OUT_MAX   = (1 << OUT_W) - 1;
  localparam int CNT_MAX   = (1 << PERIOD_W) - 1;
  localparam int LAT       = 18;
  localparam int SLOT      = 17;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      tick_en = 1'b0;
  logic [CHANNELS-1:0]       pulse = '0;
  logic [CHANNELS*OUT_W-1:0] speed_o;
  logic [CHANNELS-1:0]       upd_o;
  logic [CHANNELS-1:0]       stall_o;
  logic                      busy_o;

  typedef struct {int ch; int spd; int stl; int cyc;} upd_t;
  typedef struct {int period; int speed;} vec_t;

  upd_t upd_q[$];
  bit   hist [0:131071];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  motor_speed_recip #(
    .CHANNELS(CHANNELS), .PERIOD_W(PERIOD_W), .OUT_W(OUT_W), .NUMERATOR(NUMERATOR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .pulse(pulse),
    .speed_o(speed_o), .upd_o(upd_o), .stall_o(stall_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe is logged with its cycle so ordering and latency can be checked later.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CHANNELS; c++)
        if (upd_o[c])
          upd_q.push_back('{c, int'(speed_o[c*OUT_W +: OUT_W]), int'(stall_o[c]), cyc});
    end
  end

  initial begin
    #(85000 * 10);
    $display("[TB] FAIL watchdog: time limit reached, got cycle %0d, want finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int ref_speed(input int period);
    int q;
    if (period == 0) return OUT_MAX;
    q = NUMERATOR / period;
    if (q > OUT_MAX) return OUT_MAX;
    if (q < 1) return 1;
    return q;
  endfunction

  // Ticks seen from the cycle an edge was driven up to (not including) the next one.
  function automatic int period_since(input int from, input int upto);
    int s = 0;
    for (int x = from; x < upto; x++) s += int'(hist[x]);
    return (s > CNT_MAX) ? CNT_MAX : s;
  endfunction

  task automatic step();
    hist[cyc] = tick_en;
    @(posedge clk);
    #1;
  endtask

  task automatic stepUntil(input int t);
    while (cyc < t) step();
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CHANNELS-1:0] mask);
    pulse = mask;
    step();
    pulse = '0;
  endtask

  task automatic doReset();
    pulse = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    upd_q.delete();
  endtask

  task automatic expectUpd(input string name, input int ch, input int spd, input int stl, input int ecyc);
    upd_t r;
    int   waited = 0;
    while ((upd_q.size() == 0) && (waited < 200)) begin
      step();
      waited++;
    end
    if (upd_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no upd_o strobe, want channel %0d at cycle %0d", name, ch, ecyc);
    end else begin
      r = upd_q.pop_front();
      checkOutput({name, ".chan"},  r.ch,  ch);
      checkOutput({name, ".speed"}, r.spd, spd);
      checkOutput({name, ".stall"}, r.stl, stl);
      checkOutput({name, ".cycle"}, r.cyc, ecyc);
    end
  endtask

  initial begin
    vec_t vecs [8];
    int   s, e, a, r, n, last, prev, ch, gap, p;
    int   lastc [CHANNELS];

    vecs[0] = '{4149, 1};
    vecs[1] = '{4148, 2};
    vecs[2] = '{2766, 2};
    vecs[3] = '{83, 99};
    vecs[4] = '{82, 101};
    vecs[5] = '{33, 251};
    vecs[6] = '{32, 255};
    vecs[7] = '{9000, 1};

    // Reset values, then idle with ticks running and no pulses.
    tick_en = 1'b1;
    step();
    step();
    checkOutput("reset.speed", speed_o, 0);
    checkOutput("reset.upd",   upd_o,   0);
    checkOutput("reset.stall", stall_o, 0);
    checkOutput("reset.busy",  busy_o,  0);
    rst_n = 1'b1;
    repeat (60) step();
    checkOutput("idle.upd_count", upd_q.size(), 0);
    checkOutput("idle.stall",     stall_o,      0);
    checkOutput("idle.speed",     speed_o,      0);

    // Zero period: no ticks between two edges.
    doReset();
    tick_en = 1'b0;
    s = cyc;
    applyStimulus(4'b0010);
    stepUntil(s + 5);
    e = cyc;
    applyStimulus(4'b0010);
    expectUpd("zero", 1, OUT_MAX, 0, e + LAT);
    checkOutput("zero.speed_o", speed_o[15:8], OUT_MAX);

    // Reciprocal vectors on channel 0 while channel 3 sits armed and heads for a stall.
    doReset();
    tick_en = 1'b1;
    s = cyc;
    applyStimulus(4'b1001);
    last = s;
    for (int i = 0; i < 8; i++) begin
      stepUntil(last + vecs[i].period);
      e = cyc;
      applyStimulus(4'b0001);
      last = e;
      expectUpd($sformatf("recip[%0d]", i), 0, vecs[i].speed, 0, e + LAT);
    end
    stepUntil(s + CNT_MAX + 10);
    checkOutput("stall.pre_flags", stall_o, 0);
    expectUpd("stall", 3, 0, 1, s + CNT_MAX + LAT);
    checkOutput("stall.flags", stall_o, 4'b1000);
    repeat (20) step();
    checkOutput("stall.single", upd_q.size(), 0);
    r = cyc;
    applyStimulus(4'b1000);
    checkOutput("stall.cleared", stall_o[3], 0);
    stepUntil(r + 50);
    e = cyc;
    applyStimulus(4'b1000);
    expectUpd("stall.resume", 3, ref_speed(50), 0, e + LAT);

    // Arbitration: all four channels request at once.
    doReset();
    tick_en = 1'b1;
    a = cyc;
    applyStimulus(4'b1111);
    stepUntil(a + 40);
    e = cyc;
    applyStimulus(4'b1111);
    for (int c = 0; c < CHANNELS; c++) begin
      stepUntil(e + 10 + SLOT * c);
      checkOutput($sformatf("arb.busy[%0d]", c), busy_o, 1);
      expectUpd($sformatf("arb[%0d]", c), c, ref_speed(40), 0, e + LAT + SLOT * c);
    end

    // Overwrite: two requests on channel 2 while channel 1 is being divided.
    doReset();
    tick_en = 1'b1;
    a = cyc;
    applyStimulus(4'b0110);
    stepUntil(a + 60);
    applyStimulus(4'b0010);
    stepUntil(a + 63);
    applyStimulus(4'b0100);
    stepUntil(a + 70);
    applyStimulus(4'b0100);
    expectUpd("ovw.ch1", 1, ref_speed(60), 0, a + 60 + LAT);
    expectUpd("ovw.ch2", 2, ref_speed(7), 0, a + 60 + LAT + SLOT);
    repeat (20) step();
    checkOutput("ovw.single", upd_q.size(), 0);

    // Reset in the middle of a division.
    r = cyc;
    applyStimulus(4'b0010);
    stepUntil(r + 8);
    checkOutput("rst.busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.speed", speed_o, 0);
    checkOutput("rst.stall", stall_o, 0);
    checkOutput("rst.upd",   upd_o,   0);
    checkOutput("rst.busy",  busy_o,  0);
    step();
    step();
    rst_n = 1'b1;
    repeat (40) step();
    checkOutput("rst.no_upd",      upd_q.size(), 0);
    checkOutput("rst.speed_after", speed_o,      0);
    checkOutput("rst.busy_after",  busy_o,       0);

    // Randomized edges with a random tick pattern.
    doReset();
    tick_en = 1'b1;
    a = cyc;
    applyStimulus(4'b1111);
    for (int c = 0; c < CHANNELS; c++) lastc[c] = a;
    prev = a;
    for (n = 0; n < 12; n++) begin
      ch  = int'($urandom_range(CHANNELS - 1, 0));
      gap = int'($urandom_range(300, 20));
      while (cyc < prev + gap) begin
        tick_en = ($urandom_range(3, 0) != 0);
        step();
      end
      e = cyc;
      p = period_since(lastc[ch], e);
      lastc[ch] = e;
      prev = e;
      applyStimulus(CHANNELS'(1 << ch));
      expectUpd($sformatf("rand[%0d]", n), ch, ref_speed(p), 0, e + LAT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
